layer1_pool_stream: RTL and testbench

Downstream stage of the atrous-convolution engine. After the engine has filled the 32x32 layer1 buffer (csel=1, max-pooled, ReLU'd, 13-bit Q9.4), this block reads layer1 back through the shared memory read port. It performs a second 2x2/stride-2 max-pool, producing a 16x16 layer2 map. Each layer2 pixel and its index are streamed out over a valid/ready handshake to the next consumer.

---
 rtl/layer1_pool_stream_pkg.sv | 18 +
 rtl/layer1_pool_stream_win_addr.sv | 33 +++
 rtl/layer1_pool_stream.sv | 218 +++++++++++++++++++++
 tb/tb_layer1_pool_stream.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/layer1_pool_stream_pkg.sv
// Shared constants and FSM state type for the layer1 -> layer2 pooling stage.
// The upstream convolution engine uses the same DW/AW values.
package layer1_pool_stream_pkg;

    localparam int unsigned DW   = 13;                // pixel width (Q9.4)
    localparam int unsigned L1_W = 32;                // layer1 width = height
    localparam int unsigned L2_W = 16;                // layer2 width = height
    localparam int unsigned AW   = 12;                // memory address width
    localparam int unsigned RCW  = $clog2(L2_W);      // layer2 row/column index width

    typedef enum logic [1:0] {
        IDLE,
        READ,
        HOLD,
        DONE
    } state_e;

endpackage

// File: rtl/layer1_pool_stream_win_addr.sv
// layer1_win_addr: combinational address generator for one 2x2 pooling window.
// Ports:
//   i_r, i_c : layer2 row / column of the window
//   i_k      : which of the four window pixels (0: top-left, 1: top-right,
//              2: bottom-left, 3: bottom-right)
//   o_addr   : layer1 address L1_W*y + x of that pixel
module layer1_win_addr #(
    parameter int unsigned L1_W = layer1_pool_stream_pkg::L1_W,
    parameter int unsigned AW   = layer1_pool_stream_pkg::AW,
    parameter int unsigned RCW  = layer1_pool_stream_pkg::RCW
) (
    input  logic [RCW-1:0] i_r,
    input  logic [RCW-1:0] i_c,
    input  logic [1:0]     i_k,
    output logic [AW-1:0]  o_addr
);

    logic [AW-1:0] w_a0;

    // Top-left pixel of window (r,c) sits at row 2r, column 2c.
    assign w_a0 = AW'(i_r) * AW'(2 * L1_W) + AW'(i_c) * AW'(2);

    always_comb begin
        o_addr = w_a0;
        unique case (i_k)
            2'd0: o_addr = w_a0;
            2'd1: o_addr = w_a0 + AW'(1);
            2'd2: o_addr = w_a0 + AW'(L1_W);
            2'd3: o_addr = w_a0 + AW'(L1_W + 1);
        endcase
    end

endmodule

// File: rtl/layer1_pool_stream.sv
// layer1_pool_stream: reads the 32x32 layer1 map back through the shared
// memory read port, applies a 2x2/stride-2 max-pool and streams the 16x16
// layer2 pixels out over a valid/ready handshake.
// Ports:
//   i_clk, i_rst_n   : clock, asynchronous active-low reset
//   i_start          : one-cycle pass request, honoured only in IDLE
//   o_busy           : pass in progress
//   o_crd, o_caddr_rd: memory read strobe and address
//   i_cdata_rd       : read data, one cycle after the strobe/address edge
//   o_csel           : memory select (layer1 while busy)
//   o_out_valid/i_out_ready/o_out_data/o_out_addr : layer2 pixel stream
//   o_done           : one-cycle pulse after the last pixel transfers
module layer1_pool_stream #(
    parameter int unsigned DW   = layer1_pool_stream_pkg::DW,
    parameter int unsigned L1_W = layer1_pool_stream_pkg::L1_W,
    parameter int unsigned AW   = layer1_pool_stream_pkg::AW
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_start,
    output logic          o_busy,
    output logic          o_crd,
    output logic [AW-1:0] o_caddr_rd,
    input  logic [DW-1:0] i_cdata_rd,
    output logic          o_csel,
    output logic          o_out_valid,
    input  logic          i_out_ready,
    output logic [DW-1:0] o_out_data,
    output logic [7:0]    o_out_addr,
    output logic          o_done
);

    import layer1_pool_stream_pkg::*;

    localparam logic [2*RCW-1:0] RcOne = 1;

    state_e           r_state,  w_state_nxt;
    logic [2:0]       r_phase,  w_phase_nxt;
    logic [RCW-1:0]   r_r,      w_r_nxt;
    logic [RCW-1:0]   r_c,      w_c_nxt;
    logic [DW-1:0]    r_max,    w_max_nxt;
    logic             r_busy,   w_busy_nxt;
    logic             r_crd,    w_crd_nxt;
    logic [AW-1:0]    r_caddr,  w_caddr_nxt;
    logic             r_csel,   w_csel_nxt;
    logic             r_valid,  w_valid_nxt;
    logic [DW-1:0]    r_data,   w_data_nxt;
    logic [7:0]       r_oaddr,  w_oaddr_nxt;
    logic             r_done,   w_done_nxt;

    logic [2*RCW-1:0] w_rc_inc;
    logic [RCW-1:0]   w_win_r;
    logic [RCW-1:0]   w_win_c;
    logic [1:0]       w_win_k;
    logic [AW-1:0]    w_win_addr;
    logic [DW-1:0]    w_max_upd;

    // Row-major window index increment: c wraps 15 -> 0 and carries into r.
    assign w_rc_inc  = {r_r, r_c} + RcOne;
    // Unsigned compare; ties keep the earlier value.
    assign w_max_upd = (i_cdata_rd > r_max) ? i_cdata_rd : r_max;

    // Address generator input select: next read of the current window in
    // READ, first read of the following window in HOLD (used on transfer).
    always_comb begin
        w_win_r = r_r;
        w_win_c = r_c;
        w_win_k = 2'd0;
        if (r_state == READ) begin
            w_win_k = r_phase[1:0] + 2'd1;
        end else if (r_state == HOLD) begin
            {w_win_r, w_win_c} = w_rc_inc;
        end
    end

    layer1_win_addr #(
        .L1_W (L1_W),
        .AW   (AW),
        .RCW  (RCW)
    ) u_win_addr (
        .i_r    (w_win_r),
        .i_c    (w_win_c),
        .i_k    (w_win_k),
        .o_addr (w_win_addr)
    );

    // Next-state and registered-output logic.
    // READ phases: 0..2 issue A1..A3, 1..3 accumulate D0..D2,
    // 4 folds in D3 and presents the result.
    always_comb begin
        w_state_nxt = r_state;
        w_phase_nxt = r_phase;
        w_r_nxt     = r_r;
        w_c_nxt     = r_c;
        w_max_nxt   = r_max;
        w_busy_nxt  = r_busy;
        w_crd_nxt   = r_crd;
        w_caddr_nxt = r_caddr;
        w_csel_nxt  = r_csel;
        w_valid_nxt = r_valid;
        w_data_nxt  = r_data;
        w_oaddr_nxt = r_oaddr;
        w_done_nxt  = 1'b0;

        unique case (r_state)
            IDLE: begin
                if (i_start) begin
                    w_state_nxt = READ;
                    w_phase_nxt = 3'd0;
                    w_busy_nxt  = 1'b1;
                    w_csel_nxt  = 1'b1;
                    w_crd_nxt   = 1'b1;
                    w_caddr_nxt = w_win_addr;
                end
            end
            READ: begin
                w_phase_nxt = r_phase + 3'd1;
                case (r_phase)
                    3'd0: begin
                        w_caddr_nxt = w_win_addr;
                    end
                    3'd1: begin
                        w_caddr_nxt = w_win_addr;
                        w_max_nxt   = i_cdata_rd;
                    end
                    3'd2: begin
                        w_caddr_nxt = w_win_addr;
                        w_max_nxt   = w_max_upd;
                    end
                    3'd3: begin
                        w_crd_nxt   = 1'b0;
                        w_max_nxt   = w_max_upd;
                    end
                    default: begin
                        w_data_nxt  = w_max_upd;
                        w_oaddr_nxt = {r_r, r_c};
                        w_valid_nxt = 1'b1;
                        w_phase_nxt = 3'd0;
                        w_state_nxt = HOLD;
                    end
                endcase
            end
            HOLD: begin
                if (i_out_ready) begin
                    w_valid_nxt = 1'b0;
                    if (&r_oaddr) begin
                        w_state_nxt = DONE;
                        w_busy_nxt  = 1'b0;
                        w_csel_nxt  = 1'b0;
                        w_done_nxt  = 1'b1;
                        w_r_nxt     = '0;
                        w_c_nxt     = '0;
                    end else begin
                        {w_r_nxt, w_c_nxt} = w_rc_inc;
                        w_state_nxt = READ;
                        w_phase_nxt = 3'd0;
                        w_crd_nxt   = 1'b1;
                        w_caddr_nxt = w_win_addr;
                    end
                end
            end
            DONE: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_phase <= '0;
            r_r     <= '0;
            r_c     <= '0;
            r_max   <= '0;
            r_busy  <= 1'b0;
            r_crd   <= 1'b0;
            r_caddr <= '0;
            r_csel  <= 1'b0;
            r_valid <= 1'b0;
            r_data  <= '0;
            r_oaddr <= '0;
            r_done  <= 1'b0;
        end else begin
            r_phase <= w_phase_nxt;
            r_r     <= w_r_nxt;
            r_c     <= w_c_nxt;
            r_max   <= w_max_nxt;
            r_busy  <= w_busy_nxt;
            r_crd   <= w_crd_nxt;
            r_caddr <= w_caddr_nxt;
            r_csel  <= w_csel_nxt;
            r_valid <= w_valid_nxt;
            r_data  <= w_data_nxt;
            r_oaddr <= w_oaddr_nxt;
            r_done  <= w_done_nxt;
        end
    end

    assign o_busy      = r_busy;
    assign o_crd       = r_crd;
    assign o_caddr_rd  = r_caddr;
    assign o_csel      = r_csel;
    assign o_out_valid = r_valid;
    assign o_out_data  = r_data;
    assign o_out_addr  = r_oaddr;
    assign o_done      = r_done;

endmodule

// File: tb/tb_layer1_pool_stream.sv
// Bench for layer1_pool_stream: layer1 memory model, window-max reference
// computed directly from the pooling definition, and scenario tasks.
module tb_layer1_pool_stream;
    import layer1_pool_stream_pkg::*;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          out_ready = 1'b0;
    logic [DW-1:0] rdata = '0;
    logic          busy, crd, csel, out_valid, done;
    logic [AW-1:0] caddr;
    logic [DW-1:0] out_data;
    logic [7:0]    out_addr;

    layer1_pool_stream dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_start     (start),
        .o_busy      (busy),
        .o_crd       (crd),
        .o_caddr_rd  (caddr),
        .i_cdata_rd  (rdata),
        .o_csel      (csel),
        .o_out_valid (out_valid),
        .i_out_ready (out_ready),
        .o_out_data  (out_data),
        .o_out_addr  (out_addr),
        .o_done      (done)
    );

    always #5 clk = ~clk;

    int edge_cnt = 0;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    logic [DW-1:0] mem [0:4095];
    always @(posedge clk) if (crd) rdata <= mem[caddr];

    int n_vec = 0;
    int n_err = 0;

    // Scenario knobs (-1 disables) and per-pass observations.
    int k_rdy_pct, k_stall_win, k_spur_win, k_abort_win;
    logic [DW-1:0] cap_data [0:511];
    logic [7:0]    cap_addr [0:511];
    int n_cap, done_edge, done_cnt, e0, viol, bp_bad, bp_cnt;
    logic bp_crd_after, busy_at_done, aborted;
    logic [DW-1:0] bp_first;

    function automatic logic [DW-1:0] exp_pix(input int i);
        int r = i / 16;
        int c = i % 16;
        logic [DW-1:0] m = '0;
        for (int dy = 0; dy < 2; dy++)
            for (int dx = 0; dx < 2; dx++)
                if (mem[(2 * r + dy) * 32 + 2 * c + dx] > m)
                    m = mem[(2 * r + dy) * 32 + 2 * c + dx];
        return m;
    endfunction

    task automatic fill_ramp();
        for (int a = 0; a < 4096; a++) mem[a] = (a < 1024) ? DW'(a) : '0;
    endtask

    task automatic set_knobs(input int pct, input int stall, input int spur, input int abrt);
        k_rdy_pct = pct; k_stall_win = stall; k_spur_win = spur; k_abort_win = abrt;
    endtask

    // Pulses start and drives/records one pass; bounded by a cycle budget.
    task automatic run_pass();
        int  tail = 0;
        int  stall = 0;
        bit  pend = 0;
        bit  spur_done = 0;
        n_cap = 0; done_edge = -1; done_cnt = 0; viol = 0; bp_bad = 0; bp_cnt = 0;
        bp_crd_after = 1'b0; busy_at_done = 1'b1; aborted = 1'b0;
        out_ready = (k_rdy_pct >= 100);
        @(negedge clk);
        start = 1'b1;
        e0 = edge_cnt + 1;
        @(negedge clk);
        start = 1'b0;
        for (int cyc = 0; cyc < 20000; cyc++) begin
            if (crd && out_valid) viol++;
            if (csel !== busy) viol++;
            if (pend) begin
                bp_crd_after = crd;
                pend = 0;
            end
            if (done) begin
                done_cnt++;
                if (done_edge < 0) begin
                    done_edge = edge_cnt;
                    busy_at_done = busy;
                end
            end
            if (done_edge >= 0) begin
                tail++;
                if (tail > 20) break;
            end
            if (k_abort_win >= 0 && out_valid && out_addr == 8'(k_abort_win)) begin
                rst_n = 1'b0;
                aborted = 1'b1;
                break;
            end
            start = 1'b0;
            if (k_spur_win >= 0 && !spur_done && out_valid && out_addr == 8'(k_spur_win)) begin
                start = 1'b1;
                spur_done = 1;
            end
            out_ready = ($urandom_range(99) < k_rdy_pct);
            if (k_stall_win >= 0 && out_valid && out_addr == 8'(k_stall_win) && stall < 10) begin
                if (stall == 0) bp_first = out_data;
                else if (out_data !== bp_first) bp_bad++;
                if (crd !== 1'b0) bp_bad++;
                stall++;
                bp_cnt++;
                out_ready = 1'b0;
            end
            if (out_valid && out_ready) begin
                if (n_cap < 512) begin
                    cap_data[n_cap] = out_data;
                    cap_addr[n_cap] = out_addr;
                end
                n_cap++;
                if (k_stall_win >= 0 && out_addr == 8'(k_stall_win)) pend = 1;
            end
            @(negedge clk);
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_vec++; if (crd !== 1'b0) begin n_err++; $display("FAIL reset_crd: got %b want 0", crd); end
        n_vec++; if (caddr !== '0) begin n_err++; $display("FAIL reset_caddr: got %h want 0", caddr); end
        n_vec++; if (csel !== 1'b0) begin n_err++; $display("FAIL reset_csel: got %b want 0", csel); end
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", out_valid); end
        n_vec++; if (out_data !== '0) begin n_err++; $display("FAIL reset_data: got %h want 0", out_data); end
        n_vec++; if (out_addr !== '0) begin n_err++; $display("FAIL reset_oaddr: got %h want 0", out_addr); end
        n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b want 0", done); end
        rst_n = 1'b1;
    endtask

    task automatic test_idle_quiet();
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            n_vec++;
            if ({busy, crd, csel, out_valid, done} !== 5'b0) begin
                n_err++;
                $display("FAIL idle_quiet[%0d]: busy/crd/csel/valid/done=%b want 00000", i,
                         {busy, crd, csel, out_valid, done});
            end
        end
    endtask

    task automatic test_ramp();
        fill_ramp();
        set_knobs(100, -1, -1, -1);
        run_pass();
        n_vec++; if (n_cap != 256) begin n_err++; $display("FAIL ramp_count: got %0d want 256", n_cap); end
        for (int i = 0; i < 256 && i < n_cap; i++) begin
            n_vec++;
            if (cap_addr[i] !== 8'(i) || cap_data[i] !== exp_pix(i)) begin
                n_err++;
                $display("FAIL ramp_pix[%0d]: got addr %0d data %0d want addr %0d data %0d",
                         i, cap_addr[i], cap_data[i], i, exp_pix(i));
            end
        end
        n_vec++; if (cap_data[0] !== 13'd33) begin n_err++; $display("FAIL ramp_p0: got %0d want 33", cap_data[0]); end
        n_vec++; if (cap_data[1] !== 13'd35) begin n_err++; $display("FAIL ramp_p1: got %0d want 35", cap_data[1]); end
        n_vec++; if (cap_data[16] !== 13'd97) begin n_err++; $display("FAIL ramp_p16: got %0d want 97", cap_data[16]); end
        n_vec++; if (cap_data[255] !== 13'd1023) begin n_err++; $display("FAIL ramp_p255: got %0d want 1023", cap_data[255]); end
        n_vec++; if (done_edge - e0 != 1536) begin n_err++; $display("FAIL ramp_done_time: got %0d want 1536", done_edge - e0); end
        n_vec++; if (done_cnt != 1) begin n_err++; $display("FAIL ramp_done_cnt: got %0d want 1", done_cnt); end
        n_vec++; if (busy_at_done !== 1'b0) begin n_err++; $display("FAIL ramp_busy_at_done: got %b want 0", busy_at_done); end
        n_vec++; if (viol != 0) begin n_err++; $display("FAIL ramp_protocol: got %0d violations want 0", viol); end
    endtask

    task automatic test_unsigned();
        for (int a = 0; a < 4096; a++) mem[a] = '0;
        mem[0] = 13'h1FF0;
        set_knobs(100, -1, -1, -1);
        run_pass();
        n_vec++; if (n_cap != 256) begin n_err++; $display("FAIL uns_count: got %0d want 256", n_cap); end
        n_vec++; if (cap_data[0] !== 13'h1FF0) begin n_err++; $display("FAIL uns_p0: got %h want 1ff0", cap_data[0]); end
        for (int i = 1; i < 256 && i < n_cap; i++) begin
            n_vec++;
            if (cap_data[i] !== '0) begin
                n_err++;
                $display("FAIL uns_pix[%0d]: got %h want 0", i, cap_data[i]);
            end
        end
    endtask

    task automatic test_random();
        for (int a = 0; a < 4096; a++) mem[a] = (a < 1024) ? DW'($urandom) : '0;
        set_knobs(55, -1, -1, -1);
        run_pass();
        n_vec++; if (n_cap != 256) begin n_err++; $display("FAIL rand_count: got %0d want 256", n_cap); end
        for (int i = 0; i < 256 && i < n_cap; i++) begin
            n_vec++;
            if (cap_addr[i] !== 8'(i) || cap_data[i] !== exp_pix(i)) begin
                n_err++;
                $display("FAIL rand_pix[%0d]: got addr %0d data %h want addr %0d data %h",
                         i, cap_addr[i], cap_data[i], i, exp_pix(i));
            end
        end
        n_vec++; if (done_cnt != 1) begin n_err++; $display("FAIL rand_done_cnt: got %0d want 1", done_cnt); end
        n_vec++; if (viol != 0) begin n_err++; $display("FAIL rand_protocol: got %0d violations want 0", viol); end
    endtask

    task automatic test_backpressure();
        fill_ramp();
        set_knobs(100, 3, -1, -1);
        run_pass();
        n_vec++; if (bp_cnt != 10) begin n_err++; $display("FAIL bp_stall_cycles: got %0d want 10", bp_cnt); end
        n_vec++; if (bp_first !== exp_pix(3)) begin n_err++; $display("FAIL bp_data: got %0d want %0d", bp_first, exp_pix(3)); end
        n_vec++; if (bp_bad != 0) begin n_err++; $display("FAIL bp_stable: got %0d unstable/crd cycles want 0", bp_bad); end
        n_vec++; if (bp_crd_after !== 1'b1) begin n_err++; $display("FAIL bp_crd_after: got %b want 1", bp_crd_after); end
        n_vec++; if (n_cap != 256) begin n_err++; $display("FAIL bp_count: got %0d want 256", n_cap); end
        n_vec++; if (cap_addr[4] !== 8'd4 || cap_data[4] !== exp_pix(4)) begin
            n_err++; $display("FAIL bp_next: got addr %0d data %0d want addr 4 data %0d", cap_addr[4], cap_data[4], exp_pix(4));
        end
    endtask

    task automatic test_spurious_start();
        fill_ramp();
        set_knobs(100, -1, 50, -1);
        run_pass();
        n_vec++; if (n_cap != 256) begin n_err++; $display("FAIL spur_count: got %0d want 256", n_cap); end
        for (int i = 48; i < 56 && i < n_cap; i++) begin
            n_vec++;
            if (cap_addr[i] !== 8'(i) || cap_data[i] !== exp_pix(i)) begin
                n_err++;
                $display("FAIL spur_pix[%0d]: got addr %0d data %0d want addr %0d data %0d",
                         i, cap_addr[i], cap_data[i], i, exp_pix(i));
            end
        end
        n_vec++; if (done_cnt != 1) begin n_err++; $display("FAIL spur_done_cnt: got %0d want 1", done_cnt); end
    endtask

    task automatic test_reset_mid();
        fill_ramp();
        set_knobs(100, -1, -1, 100);
        run_pass();
        #1;
        n_vec++; if (aborted !== 1'b1) begin n_err++; $display("FAIL rstmid_reached: got %b want 1", aborted); end
        n_vec++;
        if ({busy, crd, csel, out_valid, done} !== 5'b0 || caddr !== '0 || out_data !== '0 || out_addr !== '0) begin
            n_err++;
            $display("FAIL rstmid_outputs: got flags %b caddr %h data %h addr %h want all 0",
                     {busy, crd, csel, out_valid, done}, caddr, out_data, out_addr);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_vec++; if (crd !== 1'b0) begin n_err++; $display("FAIL rstmid_crd[%0d]: got %b want 0", i, crd); end
        end
        rst_n = 1'b1;
        set_knobs(100, -1, -1, -1);
        run_pass();
        n_vec++; if (cap_addr[0] !== 8'd0 || cap_data[0] !== 13'd33) begin
            n_err++; $display("FAIL rstmid_restart: got addr %0d data %0d want addr 0 data 33", cap_addr[0], cap_data[0]);
        end
        n_vec++; if (n_cap != 256) begin n_err++; $display("FAIL rstmid_count: got %0d want 256", n_cap); end
    endtask

    initial begin
        for (int a = 0; a < 4096; a++) mem[a] = '0;
        test_reset();
        test_idle_quiet();
        test_ramp();
        test_unsigned();
        test_random();
        test_backpressure();
        test_spurious_start();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
